// File: rtl/lsu_pkg.sv
// Shared LSU request types: access size, exception causes and the stored queue entry layout.
// The entry is sized for the widest configuration; narrower builds leave the upper bits idle.
package lsu_pkg;

  typedef enum logic [1:0] {
    SizeB = 2'd0,
    SizeH = 2'd1,
    SizeW = 2'd2,
    SizeD = 2'd3
  } lsu_size_e;

  localparam logic [3:0] CauseLdMisal = 4'd4;
  localparam logic [3:0] CauseLdFault = 4'd5;
  localparam logic [3:0] CauseStMisal = 4'd6;
  localparam logic [3:0] CauseStFault = 4'd7;

  localparam int unsigned MaxXlen     = 64;
  localparam int unsigned MaxTransIdW = 8;

  typedef struct packed {
    logic [MaxXlen-1:0]     vaddr;
    logic [MaxXlen-1:0]     wdata;
    logic [MaxXlen/8-1:0]   be;
    lsu_size_e              size;
    logic                   store;
    logic [MaxTransIdW-1:0] id;
    logic                   ex_valid;
    logic [3:0]             ex_cause;
  } lsu_req_t;

endpackage

// File: rtl/lsu_addr_check.sv
// Combinational address generation: effective address, byte enables, and misaligned /
// non-canonical exception detection for one incoming request.
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned VA_BITS = 39
) (
  input  logic [XLEN-1:0]   base_i,
  input  logic [XLEN-1:0]   imm_i,
  input  lsu_size_e         size_i,
  input  logic              store_i,
  input  logic              vm_en_i,
  output logic [XLEN-1:0]   vaddr_o,
  output logic [XLEN/8-1:0] be_o,
  output logic              ex_valid_o,
  output logic [3:0]        ex_cause_o
);

  localparam int unsigned BeW  = XLEN / 8;
  localparam int unsigned OffW = $clog2(BeW);

  logic [7:0]  mask;
  logic [2:0]  align;
  logic [63:0] va64, va_hi, va_hi_ones;
  logic        misal, fault;

  always_comb begin
    mask  = 8'h01;
    align = 3'b000;
    unique case (size_i)
      SizeB: begin mask = 8'h01; align = 3'b000; end
      SizeH: begin mask = 8'h03; align = 3'b001; end
      SizeW: begin mask = 8'h0f; align = 3'b011; end
      SizeD: begin mask = 8'hff; align = 3'b111; end
    endcase

    vaddr_o = base_i + imm_i;
    be_o    = BeW'(16'(mask) << vaddr_o[OffW-1:0]);
    misal   = |(vaddr_o[2:0] & align);

    // Canonical iff every bit from VA_BITS-1 upward matches: all zeros or all ones.
    va64       = 64'(vaddr_o);
    va_hi      = va64 >> (VA_BITS - 1);
    va_hi_ones = {64{1'b1}} >> (VA_BITS - 1);
    fault      = ((XLEN == 64) && vm_en_i && (va_hi != '0) && (va_hi != va_hi_ones)) ||
                 ((XLEN == 32) && (size_i == SizeD));

    ex_valid_o = fault || misal;
    ex_cause_o = '0;
    if (fault) begin
      ex_cause_o = store_i ? CauseStFault : CauseLdFault;
    end else if (misal) begin
      ex_cause_o = store_i ? CauseStMisal : CauseLdMisal;
    end
  end

endmodule

// File: rtl/lsu_req_queue.sv
// In-order LSU request queue: checks each request at enqueue, holds up to DEPTH entries and
// optionally presents a request arriving at an empty queue on the head in the same cycle.
module lsu_req_queue
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned VA_BITS    = 39,
  parameter int unsigned TRANS_ID_W = 3,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       vm_en_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [XLEN-1:0]            req_base_i,
  input  logic [XLEN-1:0]            req_imm_i,
  input  logic [XLEN-1:0]            req_wdata_i,
  input  logic [1:0]                 req_size_i,
  input  logic                       req_store_i,
  input  logic [TRANS_ID_W-1:0]      req_trans_id_i,
  output logic                       head_valid_o,
  output logic [XLEN-1:0]            head_vaddr_o,
  output logic [XLEN-1:0]            head_wdata_o,
  output logic [XLEN/8-1:0]          head_be_o,
  output logic [1:0]                 head_size_o,
  output logic                       head_store_o,
  output logic [TRANS_ID_W-1:0]      head_trans_id_o,
  output logic                       head_ex_valid_o,
  output logic [3:0]                 head_ex_cause_o,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  lsu_req_t            mem_q [DEPTH];
  lsu_req_t            req_entry, head;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [XLEN-1:0]     vaddr;
  logic [XLEN/8-1:0]   be;
  logic                ex_valid;
  logic [3:0]          ex_cause;
  logic                push, pop, bypass_active, wr_en, rd_en;
  logic                unused_head;

  lsu_addr_check #(
    .XLEN    (XLEN),
    .VA_BITS (VA_BITS)
  ) u_addr_check (
    .base_i     (req_base_i),
    .imm_i      (req_imm_i),
    .size_i     (lsu_size_e'(req_size_i)),
    .store_i    (req_store_i),
    .vm_en_i    (vm_en_i),
    .vaddr_o    (vaddr),
    .be_o       (be),
    .ex_valid_o (ex_valid),
    .ex_cause_o (ex_cause)
  );

  always_comb begin
    req_entry          = '0;
    req_entry.vaddr    = MaxXlen'(vaddr);
    req_entry.wdata    = MaxXlen'(req_wdata_i);
    req_entry.be       = (MaxXlen/8)'(be);
    req_entry.size     = lsu_size_e'(req_size_i);
    req_entry.store    = req_store_i;
    req_entry.id       = MaxTransIdW'(req_trans_id_i);
    req_entry.ex_valid = ex_valid;
    req_entry.ex_cause = ex_cause;
  end

  // Ready depends on registered occupancy only; a pop this cycle frees space next cycle.
  assign req_ready_o   = (count_q != CntW'(DEPTH)) && !flush_i;
  assign push          = req_valid_i && req_ready_o;
  assign bypass_active = BYPASS && (count_q == '0) && push;
  assign head_valid_o  = (count_q != '0) || bypass_active;
  assign pop           = pop_i && head_valid_o && !flush_i;
  // A bypassed request popped in its arrival cycle is never written.
  assign wr_en         = push && !(bypass_active && pop);
  assign rd_en         = pop && !bypass_active;

  always_comb begin
    head = '0;
    if (head_valid_o) begin
      head = bypass_active ? req_entry : mem_q[rd_ptr_q];
    end
  end

  assign head_vaddr_o    = head.vaddr[XLEN-1:0];
  assign head_wdata_o    = head.wdata[XLEN-1:0];
  assign head_be_o       = head.be[XLEN/8-1:0];
  assign head_size_o     = head.size;
  assign head_store_o    = head.store;
  assign head_trans_id_o = head.id[TRANS_ID_W-1:0];
  assign head_ex_valid_o = head.ex_valid;
  assign head_ex_cause_o = head.ex_cause;
  assign count_o         = count_q;
  assign unused_head     = ^{head.vaddr, head.wdata, head.be, head.id};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !flush_i) begin
      mem_q[wr_ptr_q] <= req_entry;
    end
  end

endmodule
